thermostat_sequencer: RTL and testbench
=======================================

// Module: thermostat_sequencer
// PURPOSE
//  Closed-loop controller that drives the heating_dut A (heat) / B (cool) inputs.
//  Compares sampled ambient temperature against a target with a hysteresis band.
//  Enforces minimum run time and an inter-mode lockout so heat and cool never
//  chatter or overlap. Sits between the temperature sampler and heating_dut.
// PARAMETERS
//  TW          10  temperature width, unsigned, units of 0.1 degC
//  HYST        20  hysteresis half-band, 0.1 degC units (20 = 2.0 degC)
//  MIN_ON_CYC  50  minimum clock cycles a mode stays asserted once entered (>=1)
//  MIN_OFF_CYC 20  cycles both commands held low between any two modes (>=1)
// PORTS
//  clock        in   1   system clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  enable       in   1   1 = regulation allowed; 0 = wind down to IDLE
//  sample_valid in   1   1-cycle strobe: target_temp/ambient_temp valid this edge
//  target_temp  in   TW  setpoint
//  ambient_temp in   TW  measured room temperature
//  heat_cmd     out  1   drives heating_dut A
//  cool_cmd     out  1   drives heating_dut B
//  state_o      out  2   00 IDLE, 01 HEAT, 10 COOL, 11 LOCKOUT
//  lockout_o    out  1   1 while in LOCKOUT
// BEHAVIOUR
//  - Reset (async, any time): heat_cmd=0, cool_cmd=0, state_o=IDLE, lockout_o=0,
//    counters=0, stored sample invalid (have_sample=0). Takes effect without a clock edge.
//  - Sample register: at any edge with sample_valid=1, store target/ambient and set
//    have_sample=1, in every state. Decisions always use the stored copy.
//  - Arithmetic: compare in TW+2-bit signed; no wrap. need_heat = amb < tgt-HYST;
//    need_cool = amb > tgt+HYST; heat_done = amb >= tgt; cool_done = amb <= tgt.
//    tgt-HYST below 0 => never need_heat; tgt+HYST above 2^TW-1 => never need_cool.
//  - IDLE: if enable & have_sample & need_heat -> HEAT; elif need_cool -> COOL;
//    else stay. heat_cmd/cool_cmd rise on the edge after the capture edge.
//  - HEAT: heat_cmd=1, run_cnt counts from 0. Exit to LOCKOUT when
//    run_cnt >= MIN_ON_CYC-1 and (heat_done or need_cool or !enable).
//    Exit conditions before min run are held off, not dropped.
//  - COOL: mirror of HEAT with cool_cmd, cool_done, need_heat.
//  - LOCKOUT: both commands 0 for exactly MIN_OFF_CYC cycles, then IDLE.
//    IDLE re-evaluates on the following edge.
//  - Never HEAT->COOL or COOL->HEAT directly. heat_cmd & cool_cmd never both 1.
//  - enable=0 in IDLE/LOCKOUT: no effect beyond blocking IDLE exits.
//  - Outputs are registered, glitch-free, and decoded from state only.
// TESTING (bench overrides: TW=10 HYST=20 MIN_ON_CYC=4 MIN_OFF_CYC=3)
//  1 rst=1 at t0, then async rst pulse mid-HEAT -> heat/cool=0, state_o=00
//    immediately, no clock edge needed; re-entry needs a new sample_valid.
//  2 enable=1, tgt=180, amb=150 strobe -> heat_cmd=1 next edge; amb=185 after
//    1 cycle -> heat held 4 cycles total, LOCKOUT 3 cycles, then IDLE.
//  3 tgt=180, amb=170 and amb=200 -> stays IDLE (inside band); amb=201 -> COOL;
//    amb=180 -> COOL exits after min run.
//  4 HEAT active, amb jumps to 260 -> LOCKOUT >=3 cycles with both low, then COOL;
//    check heat_cmd & cool_cmd never both high (assertion).
//  5 COOL past min run, enable=0 -> LOCKOUT -> IDLE; strobe during LOCKOUT (amb=150)
//    is retained; enable=1 -> HEAT on the next edge.
//  6 Edges: tgt=10, amb=0 -> no HEAT; tgt=1015, amb=1023 -> no COOL (no wrap).

Source files
------------

// File: rtl/thermostat_sequencer.sv
// Heat/cool sequencer with hysteresis, minimum run time and inter-mode lockout.
// Commands, state and lockout flag are registered copies decoded from the next state.
module thermostat_sequencer #(
    parameter int TW          = 10,
    parameter int HYST        = 20,
    parameter int MIN_ON_CYC  = 50,
    parameter int MIN_OFF_CYC = 20
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          enable,
    input  logic          sample_valid,
    input  logic [TW-1:0] target_temp,
    input  logic [TW-1:0] ambient_temp,
    output logic          heat_cmd,
    output logic          cool_cmd,
    output logic [1:0]    state_o,
    output logic          lockout_o
);

    localparam int MAXC = (MIN_ON_CYC > MIN_OFF_CYC) ? MIN_ON_CYC : MIN_OFF_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] ON_LAST  = CW'(MIN_ON_CYC - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(MIN_OFF_CYC - 1);
    localparam logic signed [TW+1:0] HYST_S = (TW+2)'(HYST);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HEAT    = 2'b01,
        COOL    = 2'b10,
        LOCKOUT = 2'b11
    } state_t;

    state_t state, next_state;

    logic [TW-1:0] tgt_q, amb_q;
    logic          have_sample;
    logic [CW-1:0] cnt, cnt_limit;
    logic          heat_nxt, cool_nxt, lockout_nxt;

    // Two extra bits give headroom so tgt-HYST and tgt+HYST never wrap.
    logic signed [TW+1:0] tgt_s, amb_s, low_band, high_band;
    logic need_heat, need_cool, heat_done, cool_done;

    assign tgt_s     = {2'b00, tgt_q};
    assign amb_s     = {2'b00, amb_q};
    assign low_band  = tgt_s - HYST_S;
    assign high_band = tgt_s + HYST_S;
    assign need_heat = have_sample && (amb_s < low_band);
    assign need_cool = have_sample && (amb_s > high_band);
    assign heat_done = amb_s >= tgt_s;
    assign cool_done = amb_s <= tgt_s;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            tgt_q       <= '0;
            amb_q       <= '0;
            have_sample <= 1'b0;
        end else if (sample_valid) begin
            tgt_q       <= target_temp;
            amb_q       <= ambient_temp;
            have_sample <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            heat_cmd  <= 1'b0;
            cool_cmd  <= 1'b0;
            lockout_o <= 1'b0;
        end else begin
            state     <= next_state;
            heat_cmd  <= heat_nxt;
            cool_cmd  <= cool_nxt;
            lockout_o <= lockout_nxt;
            if (next_state != state)
                cnt <= '0;
            else if (cnt < cnt_limit)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        cnt_limit  = '0;
        unique case (state)
            IDLE: begin
                if (enable && have_sample) begin
                    if (need_heat)
                        next_state = HEAT;
                    else if (need_cool)
                        next_state = COOL;
                end
            end
            HEAT: begin
                cnt_limit = ON_LAST;
                if ((cnt >= ON_LAST) && (heat_done || need_cool || !enable))
                    next_state = LOCKOUT;
            end
            COOL: begin
                cnt_limit = ON_LAST;
                if ((cnt >= ON_LAST) && (cool_done || need_heat || !enable))
                    next_state = LOCKOUT;
            end
            LOCKOUT: begin
                cnt_limit = OFF_LAST;
                if (cnt >= OFF_LAST)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        heat_nxt    = (next_state == HEAT);
        cool_nxt    = (next_state == COOL);
        lockout_nxt = (next_state == LOCKOUT);
    end

    assign state_o = state;

endmodule

// File: tb/tb_thermostat_sequencer.sv
// Directed scenarios plus randomized traffic checked against a cycle-level
// model of the sequencing rules (mode + time-in-mode, integer temperature math).
module tb_thermostat_sequencer;

    localparam int TW          = 10;
    localparam int HYST        = 20;
    localparam int MIN_ON_CYC  = 4;
    localparam int MIN_OFF_CYC = 3;

    logic          clock = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          sample_valid = 1'b0;
    logic [TW-1:0] target_temp = '0;
    logic [TW-1:0] ambient_temp = '0;
    logic          heat_cmd, cool_cmd, lockout_o;
    logic [1:0]    state_o;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: mode 0 idle, 1 heat, 2 cool, 3 lockout
    int m_mode = 0;
    int m_age = 0;
    int m_tgt = 0;
    int m_amb = 0;
    bit m_have = 0;

    thermostat_sequencer #(
        .TW(TW), .HYST(HYST), .MIN_ON_CYC(MIN_ON_CYC), .MIN_OFF_CYC(MIN_OFF_CYC)
    ) dut (
        .clock(clock),
        .rst(rst),
        .enable(enable),
        .sample_valid(sample_valid),
        .target_temp(target_temp),
        .ambient_temp(ambient_temp),
        .heat_cmd(heat_cmd),
        .cool_cmd(cool_cmd),
        .state_o(state_o),
        .lockout_o(lockout_o)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        tests_run++;
        assert (!(heat_cmd === 1'b1 && cool_cmd === 1'b1)) else begin
            tests_failed++;
            $error("[TB] FAIL overlap observed heat=%0b cool=%0b expected not both 1", heat_cmd, cool_cmd);
        end
    end

    task automatic model_reset();
        m_mode = 0;
        m_age  = 0;
        m_have = 0;
        m_tgt  = 0;
        m_amb  = 0;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_edge();
        bit nh, nc, hd, cd;
        int nxt;
        nh  = m_have && (m_amb < m_tgt - HYST);
        nc  = m_have && (m_amb > m_tgt + HYST);
        hd  = (m_amb >= m_tgt);
        cd  = (m_amb <= m_tgt);
        nxt = m_mode;
        case (m_mode)
            0: if (enable && m_have) begin
                   if (nh) nxt = 1;
                   else if (nc) nxt = 2;
               end
            1: if (m_age >= MIN_ON_CYC - 1 && (hd || nc || !enable)) nxt = 3;
            2: if (m_age >= MIN_ON_CYC - 1 && (cd || nh || !enable)) nxt = 3;
            default: if (m_age >= MIN_OFF_CYC - 1) nxt = 0;
        endcase
        if (nxt != m_mode) m_age = 0;
        else m_age++;
        m_mode = nxt;
        if (sample_valid) begin
            m_tgt  = int'(target_temp);
            m_amb  = int'(ambient_temp);
            m_have = 1;
        end
    endtask

    task automatic check_value(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
        end
    endtask

    task automatic check_output(input string tag);
        check_value({tag, "_state"}, state_o, 2'(m_mode));
        check_value({tag, "_heat"}, {1'b0, heat_cmd}, {1'b0, m_mode == 1});
        check_value({tag, "_cool"}, {1'b0, cool_cmd}, {1'b0, m_mode == 2});
        check_value({tag, "_lock"}, {1'b0, lockout_o}, {1'b0, m_mode == 3});
    endtask

    task automatic apply_stimulus(input bit sv, input int tgt, input int amb, input bit en, input string tag);
        sample_valid = sv;
        target_temp  = TW'(tgt);
        ambient_temp = TW'(amb);
        enable       = en;
        @(posedge clock);
        model_edge();
        #1;
        check_output(tag);
    endtask

    task automatic idle_cycles(input int n, input bit en, input string tag);
        for (int i = 0; i < n; i++)
            apply_stimulus(1'b0, int'(target_temp), int'(ambient_temp), en, tag);
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        check_value({tag, "_heat0"}, {1'b0, heat_cmd}, 2'b00);
        check_value({tag, "_cool0"}, {1'b0, cool_cmd}, 2'b00);
        check_value({tag, "_state0"}, state_o, 2'b00);
        check_value({tag, "_lock0"}, {1'b0, lockout_o}, 2'b00);
        @(negedge clock);
        rst = 1'b0;
    endtask

    initial begin
        int tgt, amb;
        model_reset();
        #2;
        check_value("rst_state", state_o, 2'b00);
        check_value("rst_heat", {1'b0, heat_cmd}, 2'b00);
        check_value("rst_cool", {1'b0, cool_cmd}, 2'b00);
        @(negedge clock);
        rst = 1'b0;

        // Heat entry, early satisfaction held to min run, then lockout
        apply_stimulus(1, 180, 150, 1, "s2_cap");
        apply_stimulus(0, 180, 150, 1, "s2_rise");
        check_value("s2_heat_on", {1'b0, heat_cmd}, 2'b01);
        apply_stimulus(1, 180, 185, 1, "s2_done");
        idle_cycles(2, 1, "s2_hold");
        check_value("s2_heat_held", {1'b0, heat_cmd}, 2'b01);
        apply_stimulus(0, 180, 185, 1, "s2_lock");
        check_value("s2_lock_on", state_o, 2'b11);
        idle_cycles(3, 1, "s2_lockrun");
        check_value("s2_idle", state_o, 2'b00);

        // Band edges then cooling
        apply_stimulus(1, 180, 170, 1, "s3_in170");
        idle_cycles(2, 1, "s3_i170");
        apply_stimulus(1, 180, 200, 1, "s3_in200");
        idle_cycles(2, 1, "s3_i200");
        check_value("s3_band_idle", state_o, 2'b00);
        apply_stimulus(1, 180, 201, 1, "s3_cap201");
        apply_stimulus(0, 180, 201, 1, "s3_cool");
        check_value("s3_cool_on", {1'b0, cool_cmd}, 2'b01);
        apply_stimulus(1, 180, 180, 1, "s3_sat");
        idle_cycles(8, 1, "s3_exit");

        // Heat to cool must pass through lockout
        apply_stimulus(1, 180, 100, 1, "s4_cap");
        idle_cycles(2, 1, "s4_heat");
        apply_stimulus(1, 180, 260, 1, "s4_jump");
        idle_cycles(10, 1, "s4_swap");
        check_value("s4_cooling", state_o, 2'b10);

        // Wind down by enable, strobe retained through lockout
        idle_cycles(4, 1, "s5_run");
        apply_stimulus(0, 180, 260, 0, "s5_off");
        apply_stimulus(1, 180, 150, 0, "s5_strobe");
        idle_cycles(5, 0, "s5_wait");
        check_value("s5_idle_dis", state_o, 2'b00);
        apply_stimulus(0, 180, 150, 1, "s5_heat");
        check_value("s5_heat_on", {1'b0, heat_cmd}, 2'b01);

        // Async reset mid-heat, then no re-entry without a new sample
        idle_cycles(1, 1, "s1_pre");
        async_reset("s1_async");
        idle_cycles(3, 1, "s1_nosample");
        check_value("s1_stay_idle", state_o, 2'b00);

        // No-wrap boundaries
        apply_stimulus(1, 10, 0, 1, "s6_low");
        idle_cycles(2, 1, "s6_lowi");
        check_value("s6_no_heat", state_o, 2'b00);
        apply_stimulus(1, 1015, 1023, 1, "s6_high");
        idle_cycles(2, 1, "s6_highi");
        check_value("s6_no_cool", state_o, 2'b00);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            tgt = 100 + int'($urandom_range(0, 200));
            amb = tgt - 60 + int'($urandom_range(0, 120));
            apply_stimulus(($urandom_range(0, 3) == 0), tgt, amb, ($urandom_range(0, 9) != 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
